rssb_sequencer: RTL

RSSB_SEQUENCER -- requirements
Module: rssb_sequencer

---
 rtl/rssb_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/rssb_sequencer.sv
// ---------------------------------------------------------------------------
// rssb_sequencer : control FSM for a single-instruction RSSB processor
// Revision 1.0   : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rssb_sequencer #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   HALT_OP = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             neg,
  output logic             write_pc,
  output logic             write_op1,
  output logic             write_acc,
  output logic             write_mem,
  output logic             sel_pc,
  output logic             sel_mem,
  output logic             busy,
  output logic             halted,
  output logic [WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_NEXT   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_neg_q;
  logic [WIDTH-1:0] r_count;
  logic             w_is_halt;

  assign w_is_halt = (mem_rdata == HALT_OP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_neg_q <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) r_state <= w_is_halt ? S_HALTED : S_EXEC;
        end
        S_EXEC: begin
          if (mem_ready) begin
            r_neg_q <= neg;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          r_count <= r_count + 1'b1;
          r_state <= S_FETCH;
        end
        S_HALTED: r_state <= S_HALTED;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is held so nothing leaks mid-reset.
  always_comb begin
    write_pc  = 1'b0;
    write_op1 = 1'b0;
    write_acc = 1'b0;
    write_mem = 1'b0;
    sel_pc    = 1'b0;
    sel_mem   = 1'b0;
    busy      = 1'b0;
    halted    = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          write_op1 = mem_ready;
          busy      = 1'b1;
        end
        S_EXEC: begin
          sel_mem   = 1'b1;
          write_acc = mem_ready;
          write_mem = mem_ready;
          busy      = 1'b1;
        end
        S_NEXT: begin
          write_pc = 1'b1;
          sel_pc   = r_neg_q;
          busy     = 1'b1;
        end
        S_HALTED: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign instr_count = rst ? r_count : '0;

endmodule

`default_nettype wire
